// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_pkg
//  Description : Shared types and timing defaults for the RTC bus scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_bus_pkg;

    localparam int T_PULSO_DEF = 10;
    localparam int T_GAP_DEF   = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP1 = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP2 = 3'd4
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_fase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_fase_timer
//  Description : Down-counting phase timer; done is high on the last cycle
//                of a phase. length is the phase length minus one.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_fase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] length,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Counter parks at zero so it never wraps inside a phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= length;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/rtc_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_bus_scheduler
//  Description : Round-robin scheduler sequencing RTC bus reads and writes
//                through address / gap / data / gap strobe phases.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_scheduler
    import rtc_bus_pkg::*;
#(
    parameter int T_PULSO = T_PULSO_DEF,
    parameter int T_GAP   = T_GAP_DEF
) (
    input  logic       reloj,
    input  logic       resetM,
    input  logic       req_wr,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       ack_wr,
    input  logic       req_rd,
    input  logic [7:0] rd_addr,
    output logic       ack_rd,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       A_D,
    output logic [7:0] dir_out,
    output logic       dir_oe,
    input  logic [7:0] dir_in
);

    localparam int                 C_CNT_W     = $clog2(max_int(T_PULSO, T_GAP));
    localparam logic [C_CNT_W-1:0] C_LEN_PULSO = C_CNT_W'(T_PULSO - 1);
    localparam logic [C_CNT_W-1:0] C_LEN_GAP   = C_CNT_W'(T_GAP - 1);

    state_e       state_q, state_d;
    op_e          op_q, op_d;
    op_e          last_q, last_d;
    logic [7:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;
    logic [7:0]   rd_data_q, rd_data_d;

    logic               w_load;
    logic [C_CNT_W-1:0] w_len;
    logic               w_done;
    logic               w_pick_rd;

    rtc_fase_timer #(
        .W      (C_CNT_W)
    ) u_timer (
        .clk    (reloj),
        .rst    (resetM),
        .load   (w_load),
        .length (w_len),
        .done   (w_done)
    );

    always_ff @(posedge reloj) begin
        if (resetM) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RD;
            last_q    <= OP_WR;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Read wins unless only a write is pending or the read was served last.
    assign w_pick_rd = req_rd && (!req_wr || (last_q == OP_WR));

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        last_d    = last_q;
        addr_d    = addr_q;
        data_d    = data_q;
        rd_data_d = rd_data_q;
        w_load    = 1'b0;
        w_len     = C_LEN_PULSO;

        CS      = 1'b1;
        RD      = 1'b1;
        WR      = 1'b1;
        A_D     = 1'b1;
        dir_oe  = 1'b0;
        dir_out = 8'h00;
        ack_wr  = 1'b0;
        ack_rd  = 1'b0;
        busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (req_rd || req_wr) begin
                    w_load  = 1'b1;
                    w_len   = C_LEN_PULSO;
                    state_d = ST_ADDR;
                    if (w_pick_rd) begin
                        op_d   = OP_RD;
                        last_d = OP_RD;
                        addr_d = rd_addr;
                    end else begin
                        op_d   = OP_WR;
                        last_d = OP_WR;
                        addr_d = wr_addr;
                        data_d = wr_data;
                    end
                end
            end
            ST_ADDR: begin
                CS      = 1'b0;
                A_D     = 1'b0;
                WR      = 1'b0;
                dir_oe  = 1'b1;
                dir_out = addr_q;
                if (w_done) begin
                    w_load  = 1'b1;
                    w_len   = C_LEN_GAP;
                    state_d = ST_GAP1;
                end
            end
            ST_GAP1: begin
                if (w_done) begin
                    w_load  = 1'b1;
                    w_len   = C_LEN_PULSO;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                CS = 1'b0;
                if (op_q == OP_WR) begin
                    WR      = 1'b0;
                    dir_oe  = 1'b1;
                    dir_out = data_q;
                end else begin
                    RD = 1'b0;
                end
                if (w_done) begin
                    w_load  = 1'b1;
                    w_len   = C_LEN_GAP;
                    state_d = ST_GAP2;
                    if (op_q == OP_RD) begin
                        rd_data_d = dir_in;
                    end
                end
            end
            ST_GAP2: begin
                if (w_done) begin
                    ack_wr  = (op_q == OP_WR);
                    ack_rd  = (op_q == OP_RD);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtc_bus_scheduler
//  Description : Self-checking bench for rtc_bus_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_scheduler;

    localparam int TP  = 10;
    localparam int TG  = 5;
    localparam int TOT = 2 * TP + 2 * TG;

    logic       reloj = 1'b0;
    logic       resetM = 1'b1;
    logic       req_wr = 1'b0, req_rd = 1'b0;
    logic [7:0] wr_addr = 8'h00, wr_data = 8'h00, rd_addr = 8'h00, dir_in = 8'h00;
    logic       ack_wr, ack_rd, busy, CS, RD, WR, A_D, dir_oe;
    logic [7:0] rd_data, dir_out;

    int n_checks = 0;
    int n_fail   = 0;

    rtc_bus_scheduler #(
        .T_PULSO (TP),
        .T_GAP   (TG)
    ) dut (
        .reloj   (reloj),
        .resetM  (resetM),
        .req_wr  (req_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ack_wr  (ack_wr),
        .req_rd  (req_rd),
        .rd_addr (rd_addr),
        .ack_rd  (ack_rd),
        .rd_data (rd_data),
        .busy    (busy),
        .CS      (CS),
        .RD      (RD),
        .WR      (WR),
        .A_D     (A_D),
        .dir_out (dir_out),
        .dir_oe  (dir_oe),
        .dir_in  (dir_in)
    );

    always #5 reloj = ~reloj;

    // Transaction-level reference: a transaction is an offset 1..TOT into
    // the fixed 30-cycle frame; everything follows from the offset.
    bit         m_busy    = 1'b0;
    int         m_off     = 0;
    bit         m_op_wr   = 1'b0;
    bit         m_last_wr = 1'b1;
    logic [7:0] m_addr    = 8'h00;
    logic [7:0] m_data    = 8'h00;
    logic [7:0] m_rd_data = 8'h00;

    task automatic model_edge();
        bit pick_wr;
        if (resetM) begin
            m_busy    = 1'b0;
            m_off     = 0;
            m_last_wr = 1'b1;
            m_rd_data = 8'h00;
        end else if (!m_busy) begin
            if (req_rd || req_wr) begin
                pick_wr   = req_wr && !(req_rd && m_last_wr);
                m_busy    = 1'b1;
                m_off     = 1;
                m_op_wr   = pick_wr;
                m_last_wr = pick_wr;
                m_addr    = pick_wr ? wr_addr : rd_addr;
                m_data    = wr_data;
            end
        end else begin
            if (m_off == 2 * TP + TG && !m_op_wr) m_rd_data = dir_in;
            if (m_off == TOT) begin
                m_busy = 1'b0;
                m_off  = 0;
            end else begin
                m_off = m_off + 1;
            end
        end
    endtask

    // {CS,RD,WR,A_D,dir_oe,busy,ack_wr,ack_rd}
    function automatic logic [7:0] exp_ctl();
        if (!m_busy)              return 8'b1111_0000;
        if (m_off <= TP)          return 8'b0100_1100;
        if (m_off <= TP + TG)     return 8'b1111_0100;
        if (m_off <= 2 * TP + TG) return m_op_wr ? 8'b0101_1100 : 8'b0011_0100;
        if (m_off < TOT)          return 8'b1111_0100;
        return m_op_wr ? 8'b1111_0110 : 8'b1111_0101;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail < 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [7:0] e;
        @(posedge reloj);
        model_edge();
        #1;
        e = exp_ctl();
        chk8("ctl_vs_model", {CS, RD, WR, A_D, dir_oe, busy, ack_wr, ack_rd}, e);
        chk8("rd_data_vs_model", rd_data, m_rd_data);
        if (e[3]) chk8("dir_out_vs_model", dir_out, (m_off <= TP) ? m_addr : m_data);
        chk8("proto_oe_while_rd", {7'd0, dir_oe & ~RD}, 8'd0);
        chk8("proto_cs_when_idle", {7'd0, ~CS & ~busy}, 8'd0);
    endtask

    // Runs one transaction from the current idle point to its ack.
    task automatic wait_txn(output bit saw_wr, output logic [7:0] a_dout,
                            output logic [7:0] d_dout, output logic d_rd,
                            output logic d_wr, output int lat);
        bit done;
        saw_wr = 1'b0; a_dout = 8'h00; d_dout = 8'h00; d_rd = 1'b1; d_wr = 1'b1;
        lat = 0; done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            tick();
            if (busy) begin
                lat++;
                if (lat == 1) a_dout = dir_out;
                if (lat == TP + TG + 1) begin
                    d_dout = dir_out; d_rd = RD; d_wr = WR;
                end
                if (ack_wr || ack_rd) begin
                    done = 1'b1; saw_wr = ack_wr;
                end
            end
        end
        chk32("txn_timeout", int'(done), 1);
    endtask

    typedef struct {
        logic       is_wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        logic [7:0] exp_addr;
        logic [7:0] exp_data;
        logic [7:0] exp_rd;
        int         exp_lat;
    } vec_t;

    vec_t vec [6];

    initial begin
        bit         s_wr;
        logic [7:0] a_d, d_d;
        logic       d_r, d_w;
        int         lat, n;

        vec[0] = '{1'b1, 8'h21, 8'h45, 8'h00, 8'h21, 8'h45, 8'h00, 30};
        vec[1] = '{1'b0, 8'h24, 8'h00, 8'h59, 8'h24, 8'h00, 8'h59, 30};
        vec[2] = '{1'b1, 8'hFF, 8'h00, 8'hAA, 8'hFF, 8'h00, 8'h00, 30};
        vec[3] = '{1'b0, 8'h00, 8'h13, 8'hA5, 8'h00, 8'h00, 8'hA5, 30};
        vec[4] = '{1'b1, 8'h80, 8'h7F, 8'h00, 8'h80, 8'h7F, 8'h00, 30};
        vec[5] = '{1'b0, 8'h7E, 8'hEE, 8'h3C, 8'h7E, 8'h00, 8'h3C, 30};

        // Reset hold
        resetM = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk8("rst_strobes", {4'd0, CS, RD, WR, A_D}, 8'h0F);
            chk8("rst_oe_busy_ack", {4'd0, dir_oe, busy, ack_wr, ack_rd}, 8'h00);
            chk8("rst_dir_out", dir_out, 8'h00);
            chk8("rst_rd_data", rd_data, 8'h00);
        end
        resetM = 1'b0;
        tick();

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            if (vec[i].is_wr) begin
                req_wr = 1'b1; wr_addr = vec[i].addr; wr_data = vec[i].wdata;
            end else begin
                req_rd = 1'b1; rd_addr = vec[i].addr;
            end
            dir_in = vec[i].din;
            wait_txn(s_wr, a_d, d_d, d_r, d_w, lat);
            chk8("vec_op", {7'd0, s_wr}, {7'd0, vec[i].is_wr});
            chk8("vec_addr_phase", a_d, vec[i].exp_addr);
            chk32("vec_latency", lat, vec[i].exp_lat);
            if (vec[i].is_wr) begin
                chk8("vec_data_phase", d_d, vec[i].exp_data);
                chk8("vec_wr_strobe", {6'd0, d_r, d_w}, 8'h02);
            end else begin
                chk8("vec_rd_strobe", {6'd0, d_r, d_w}, 8'h01);
                chk8("vec_rd_data", rd_data, vec[i].exp_rd);
            end
            req_wr = 1'b0; req_rd = 1'b0;
            tick();
        end

        // Contention after reset: read, then write, then read wins the next tie
        resetM = 1'b1; tick(); resetM = 1'b0;
        req_rd = 1'b1; rd_addr = 8'h24; req_wr = 1'b1; wr_addr = 8'h21; wr_data = 8'h45;
        dir_in = 8'h66;
        wait_txn(s_wr, a_d, d_d, d_r, d_w, lat);
        chk8("tie1_is_read", {7'd0, s_wr}, 8'h00);
        chk8("tie1_addr", a_d, 8'h24);
        chk8("tie1_rd_data", rd_data, 8'h66);
        req_rd = 1'b0;
        wait_txn(s_wr, a_d, d_d, d_r, d_w, lat);
        chk8("tie1_then_write", {7'd0, s_wr}, 8'h01);
        chk8("tie1_write_addr", a_d, 8'h21);
        chk8("tie1_write_data", d_d, 8'h45);
        req_rd = 1'b1; rd_addr = 8'h30;
        wait_txn(s_wr, a_d, d_d, d_r, d_w, lat);
        chk8("tie2_is_read", {7'd0, s_wr}, 8'h00);
        chk8("tie2_addr", a_d, 8'h30);
        req_rd = 1'b0;
        wait_txn(s_wr, a_d, d_d, d_r, d_w, lat);
        chk8("tie2_then_write", {7'd0, s_wr}, 8'h01);
        req_wr = 1'b0;
        tick();

        // Reset during the DATA phase of a write
        req_wr = 1'b1; wr_addr = 8'h33; wr_data = 8'h77;
        n = 0;
        for (int c = 0; c < 60 && n < 18; c++) begin
            tick();
            if (busy) n++;
        end
        chk32("midrst_reach_data", n, 18);
        chk8("midrst_in_data", {7'd0, WR}, 8'h00);
        wr_addr = 8'hC1; wr_data = 8'hC2;
        resetM = 1'b1;
        tick();
        resetM = 1'b0; req_wr = 1'b0;
        chk8("midrst_strobes", {4'd0, CS, RD, WR, A_D}, 8'h0F);
        chk8("midrst_oe_busy_ack", {5'd0, dir_oe, busy, ack_wr}, 8'h00);
        for (int c = 0; c < 35; c++) begin
            tick();
            chk8("midrst_no_ack", {7'd0, ack_wr}, 8'h00);
        end

        // Randomized traffic against the reference model
        for (int c = 0; c < 4000; c++) begin
            bit a_r, a_w;
            a_r = m_busy && (m_off == TOT) && !m_op_wr;
            a_w = m_busy && (m_off == TOT) && m_op_wr;
            if (a_r) req_rd = 1'b0;
            else if (req_rd && $urandom_range(0, 59) == 0) req_rd = 1'b0;
            else if (!req_rd && $urandom_range(0, 3) == 0) req_rd = 1'b1;
            if (a_w) req_wr = 1'b0;
            else if (req_wr && $urandom_range(0, 59) == 0) req_wr = 1'b0;
            else if (!req_wr && $urandom_range(0, 3) == 0) req_wr = 1'b1;
            rd_addr = 8'($urandom);
            wr_addr = 8'($urandom);
            wr_data = 8'($urandom);
            dir_in  = 8'($urandom);
            resetM  = ($urandom_range(0, 399) == 0);
            tick();
        end
        resetM = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        for (int c = 0; c < 35; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
